// File: rtl/conv_window_gen.sv
// Sliding-window generator feeding the convolution engine. It buffers KERNEL-1 lines
// and emits one KERNEL x KERNEL window per channel at every stride-1 position.
module conv_window_gen #(
    parameter int CL_IN  = 9,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CL_IN*N-1:0]                d_in,
    input  logic                              en_in,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0]  data2conv,
    output logic                              en_out,
    output logic                              last_out
);
    localparam int PW = CL_IN * N;
    localparam int KK = KERNEL * KERNEL;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end, row_end;
    logic          row_ok, col_ok, win_ok;

    assign col_end = (col == CW'(IMG_W - 1));
    assign row_end = (row == RW'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (en_in) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // new_col[r] is the column entering the window, r=0 being the oldest line
    logic [KERNEL-1:0][PW-1:0]              new_col;
    logic [KERNEL-1:0][KERNEL-1:0][PW-1:0]  win_nxt;

    assign new_col[KERNEL-1] = d_in;

    generate
        if (KERNEL > 1) begin : g_buf
            // lb[0] is the youngest buffered line; all lines share the column pointer
            logic [PW-1:0]                         lb [KERNEL-1][IMG_W];
            logic [KERNEL-1:0][KERNEL-2:0][PW-1:0] hist;

            always_ff @(posedge clk) begin
                if (en_in) begin
                    lb[0][col] <= d_in;
                    for (int k = 1; k < KERNEL - 1; k++)
                        lb[k][col] <= lb[k-1][col];
                    for (int r = 0; r < KERNEL; r++)
                        for (int c = 0; c < KERNEL - 1; c++)
                            hist[r][c] <= win_nxt[r][c+1];
                end
            end

            for (genvar k = 0; k < KERNEL - 1; k++) begin : g_rd
                assign new_col[KERNEL-2-k] = lb[k][col];
            end
            for (genvar r = 0; r < KERNEL; r++) begin : g_hr
                for (genvar c = 0; c < KERNEL - 1; c++) begin : g_hc
                    assign win_nxt[r][c] = hist[r][c];
                end
            end

            assign row_ok = (row >= RW'(KERNEL - 1));
            assign col_ok = (col >= CW'(KERNEL - 1));
        end else begin : g_nobuf
            assign row_ok = 1'b1;
            assign col_ok = 1'b1;
        end
    endgenerate

    for (genvar r = 0; r < KERNEL; r++) begin : g_nc
        assign win_nxt[r][KERNEL-1] = new_col[r];
    end

    // Repack into the CE layout: channel-major, then element r*KERNEL+c
    logic [CL_IN*KK*N-1:0] win_flat;
    for (genvar i = 0; i < CL_IN; i++) begin : g_ch
        for (genvar r = 0; r < KERNEL; r++) begin : g_r
            for (genvar c = 0; c < KERNEL; c++) begin : g_c
                assign win_flat[(i*KK + r*KERNEL + c)*N +: N] = win_nxt[r][c][i*N +: N];
            end
        end
    end

    assign win_ok = en_in && row_ok && col_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_out    <= 1'b0;
            last_out  <= 1'b0;
            data2conv <= '0;
        end else begin
            en_out   <= win_ok;
            last_out <= win_ok && row_end && col_end;
            if (win_ok)
                data2conv <= win_flat;
        end
    end
endmodule
